ps2_scancode_decoder: RTL

- Sits directly downstream of PS2_Controller. Consumes its raw byte stream (received_data / received_data_en).
- Parses PS/2 Set-2 make, break (F0), extended (E0) and Pause (E1) sequences into single key events.
- Buffers the events in a show-ahead FIFO with a valid/ready handshake, for display logic or other key consumers.
- Replaces ad-hoc F0 tracking at top level with a single reusable event source.

---
 rtl/ps2_scancode_decoder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder.
// Turns the raw byte stream from PS2_Controller into single key events
// (make/break, E0-extended, Pause) and queues them in a show-ahead FIFO.
//
// Handshake: event_valid is high whenever the FIFO holds an event, and the head
// fields are stable while it is high. The head event is consumed on every
// rising edge where event_valid && event_ready. event_ready while empty has
// no effect.
module ps2_scancode_decoder #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [7:0]             received_data,
  input  logic                   received_data_en,
  input  logic                   event_ready,
  output logic                   event_valid,
  output logic [7:0]             event_code,
  output logic                   event_extended,
  output logic                   event_release,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   sync_error,
  output logic [2:0]             debug_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE      = AW'(1);
  // Pause is E1 followed by seven more bytes
  localparam logic [2:0]    SKIP_LEN     = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_F0   = 3'd1,
    GOT_E0   = 3'd2,
    GOT_E0F0 = 3'd3,
    SKIP     = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } event_t;

  state_t        state, state_nxt;
  logic [2:0]    skip_cnt, skip_nxt;
  logic [TW-1:0] timer;
  logic          err_nxt;
  logic          push_req;
  event_t        push_ev;

  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, pop, push_ok;
  event_t        head;

  // Keyboard status/acknowledge bytes that never start or finish a key event
  function automatic logic is_non_key(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_non_key = 1'b1;
      default:                                                is_non_key = 1'b0;
    endcase
  endfunction

  // Byte decode: next state, event to push and abandoned-sequence flag
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    err_nxt   = 1'b0;
    push_req  = 1'b0;
    push_ev   = '0;
    if (received_data_en) begin
      case (state)
        IDLE: begin
          if (is_non_key(received_data)) begin
            state_nxt = IDLE;
          end else if (received_data == 8'hF0) begin
            state_nxt = GOT_F0;
          end else if (received_data == 8'hE0) begin
            state_nxt = GOT_E0;
          end else if (received_data == 8'hE1) begin
            state_nxt = SKIP;
            skip_nxt  = SKIP_LEN;
          end else begin
            push_req = 1'b1;
            push_ev  = {received_data, 1'b0, 1'b0};
          end
        end
        GOT_F0: begin
          if (received_data == 8'hF0) begin
            state_nxt = GOT_F0;
          end else if (is_non_key(received_data) ||
                       received_data == 8'hE0 || received_data == 8'hE1) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
            push_req  = 1'b1;
            push_ev   = {received_data, 1'b0, 1'b1};
          end
        end
        GOT_E0: begin
          if (is_non_key(received_data) || received_data == 8'hE1) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else if (received_data == 8'hE0) begin
            state_nxt = GOT_E0;
          end else if (received_data == 8'hF0) begin
            state_nxt = GOT_E0F0;
          end else if (received_data == 8'h12) begin
            // fake shift emitted around Print Screen and friends
            state_nxt = IDLE;
          end else begin
            state_nxt = IDLE;
            push_req  = 1'b1;
            push_ev   = {received_data, 1'b1, 1'b0};
          end
        end
        GOT_E0F0: begin
          if (is_non_key(received_data) || received_data == 8'hF0 ||
              received_data == 8'hE0 || received_data == 8'hE1) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else if (received_data == 8'h12) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = IDLE;
            push_req  = 1'b1;
            push_ev   = {received_data, 1'b1, 1'b1};
          end
        end
        SKIP: begin
          if (skip_cnt == 3'd1) begin
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
            push_req  = 1'b1;
            push_ev   = {8'hE1, 1'b1, 1'b0};
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && timer == TIMEOUT_LAST) begin
      state_nxt = IDLE;
      skip_nxt  = 3'd0;
      err_nxt   = 1'b1;
    end
  end

  // Sequence FSM registers, idle timeout counter and sync_error pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      skip_cnt   <= 3'd0;
      timer      <= '0;
      sync_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      skip_cnt   <= skip_nxt;
      sync_error <= err_nxt;
      if (received_data_en || state == IDLE || err_nxt) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_ONE;
      end
    end
  end

  assign debug_state = state;

  assign event_valid = (fifo_count != '0);
  assign fifo_full   = (fifo_count == FULL_COUNT);
  assign pop         = event_valid & event_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok     = push_req & (~fifo_full | pop);

  // Event storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLOCK_50) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_ev;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + COUNT_ONE;
        2'b01:   fifo_count <= fifo_count - COUNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr];
  assign event_code     = event_valid ? head.code : 8'h00;
  assign event_extended = event_valid & head.ext;
  assign event_release  = event_valid & head.rel;

endmodule
